// File: rtl/bus_sched_pkg.sv
// Shared types for the PET bus time-division scheduler.
package bus_sched_pkg;

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_VIDEO    = 2'd0,
        SLOT_SPI      = 2'd1,
        SLOT_CPU_ADDR = 2'd2,
        SLOT_CPU_DATA = 2'd3
    } slot_t;

endpackage

// File: rtl/bus_scheduler_slot_timer.sv
// Free-running frame counter with slot/phase decode of the value the counter
// takes on the coming edge, so the scheduler can register its outputs in step.
module slot_timer
    import bus_sched_pkg::*;
#(
    parameter int SLOT_LEN = 4
) (
    input  logic       clk16_i,
    input  logic       reset_i,
    output logic [1:0] slot_o,
    output logic [1:0] nxt_slot_o,
    output logic       nxt_first_o,
    output logic       nxt_last_o,
    output logic       nxt_second_half_o
);

    localparam int CW = $clog2(NUM_SLOTS * SLOT_LEN);
    localparam int PW = $clog2(SLOT_LEN);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_LEN - 1);

    logic [CW-1:0] ctr_q, ctr_d;
    logic          run_q, run_d;
    logic [PW-1:0] nxt_phase;

    // The release edge re-enters count 0 rather than advancing, so the first
    // cycle out of reset is phase 0 of the video slot.
    always_comb begin
        run_d = 1'b1;
        ctr_d = ctr_q + CW'(1);
        if (!run_q) begin
            ctr_d = '0;
        end
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            ctr_q <= '0;
            run_q <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            run_q <= run_d;
        end
    end

    assign nxt_phase         = ctr_d[PW-1:0];
    assign nxt_first_o       = (nxt_phase == '0);
    assign nxt_last_o        = (nxt_phase == LAST_PHASE);
    assign nxt_second_half_o = nxt_phase[PW-1];
    assign nxt_slot_o        = ctr_d[CW-1 -: 2];
    assign slot_o            = ctr_q[CW-1 -: 2];

endmodule

// File: rtl/bus_scheduler.sv
// Four-slot time-division scheduler for the shared PET bus (video, SPI, CPU).
// Optional BUS_SCHED_SPI_STEAL_EN lets SPI use an idle video slot.
module bus_scheduler
    import bus_sched_pkg::*;
#(
    parameter int SLOT_LEN = 4
) (
    input  logic       clk16_i,
    input  logic       reset_i,
    input  logic       spi_valid_i,
    output logic       spi_ready_o,
    output logic       spi_en_o,
    input  logic       vid_req_i,
    output logic       vid_ack_o,
    output logic       vid_en_o,
    output logic       cpu_en_o,
    output logic       cpu_be_o,
    output logic       cpu_clk_o,
    output logic       strobe_o,
    output logic [1:0] slot_o
);

    logic [1:0] nxt_slot_raw;
    logic       nxt_first, nxt_last, nxt_second_half;
    slot_t      nxt_slot;

    slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
        .clk16_i           (clk16_i),
        .reset_i           (reset_i),
        .slot_o            (slot_o),
        .nxt_slot_o        (nxt_slot_raw),
        .nxt_first_o       (nxt_first),
        .nxt_last_o        (nxt_last),
        .nxt_second_half_o (nxt_second_half)
    );

    assign nxt_slot = slot_t'(nxt_slot_raw);

    logic vid_en_q, vid_en_d;
    logic spi_en_q, spi_en_d;
    logic vid_ack_q, vid_ack_d;
    logic spi_ready_q, spi_ready_d;
    logic cpu_en_q, cpu_en_d;
    logic cpu_be_q, cpu_be_d;
    logic cpu_clk_q, cpu_clk_d;
    logic strobe_q, strobe_d;

    // Grants are sampled only on the edge entering phase 0 and then held.
    always_comb begin
        vid_en_d = vid_en_q;
        spi_en_d = spi_en_q;
        if (nxt_first) begin
            vid_en_d = 1'b0;
            spi_en_d = 1'b0;
            case (nxt_slot)
                SLOT_VIDEO: begin
                    vid_en_d = vid_req_i;
`ifdef BUS_SCHED_SPI_STEAL_EN
                    spi_en_d = !vid_req_i && spi_valid_i;
`else
                    spi_en_d = 1'b0;
`endif
                end
                SLOT_SPI: spi_en_d = spi_valid_i;
                default: begin
                    vid_en_d = 1'b0;
                    spi_en_d = 1'b0;
                end
            endcase
        end

        cpu_en_d    = (nxt_slot == SLOT_CPU_DATA);
        cpu_clk_d   = (nxt_slot == SLOT_CPU_DATA);
        cpu_be_d    = (nxt_slot == SLOT_CPU_ADDR) || (nxt_slot == SLOT_CPU_DATA);
        strobe_d    = nxt_second_half && (vid_en_d || spi_en_d || cpu_en_d);
        vid_ack_d   = nxt_last && vid_en_d;
        spi_ready_d = nxt_last && spi_en_d;
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            vid_en_q    <= 1'b0;
            spi_en_q    <= 1'b0;
            vid_ack_q   <= 1'b0;
            spi_ready_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_be_q    <= 1'b0;
            cpu_clk_q   <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            vid_en_q    <= vid_en_d;
            spi_en_q    <= spi_en_d;
            vid_ack_q   <= vid_ack_d;
            spi_ready_q <= spi_ready_d;
            cpu_en_q    <= cpu_en_d;
            cpu_be_q    <= cpu_be_d;
            cpu_clk_q   <= cpu_clk_d;
            strobe_q    <= strobe_d;
        end
    end

    assign vid_en_o    = vid_en_q;
    assign spi_en_o    = spi_en_q;
    assign vid_ack_o   = vid_ack_q;
    assign spi_ready_o = spi_ready_q;
    assign cpu_en_o    = cpu_en_q;
    assign cpu_be_o    = cpu_be_q;
    assign cpu_clk_o   = cpu_clk_q;
    assign strobe_o    = strobe_q;

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler: SLOT_LEN=4 instance plus an idle SLOT_LEN=8 instance.
module tb_bus_scheduler;

    logic clk16;
    logic reset;
    logic spi_valid, vid_req;

    logic a_spi_ready, a_spi_en, a_vid_ack, a_vid_en, a_cpu_en, a_cpu_be, a_cpu_clk, a_strobe;
    logic [1:0] a_slot;
    logic b_spi_ready, b_spi_en, b_vid_ack, b_vid_en, b_cpu_en, b_cpu_be, b_cpu_clk, b_strobe;
    logic [1:0] b_slot;

    int n_cmp = 0;
    int n_err = 0;

    bus_scheduler #(.SLOT_LEN(4)) dut_a (
        .clk16_i(clk16), .reset_i(reset),
        .spi_valid_i(spi_valid), .spi_ready_o(a_spi_ready), .spi_en_o(a_spi_en),
        .vid_req_i(vid_req), .vid_ack_o(a_vid_ack), .vid_en_o(a_vid_en),
        .cpu_en_o(a_cpu_en), .cpu_be_o(a_cpu_be), .cpu_clk_o(a_cpu_clk),
        .strobe_o(a_strobe), .slot_o(a_slot)
    );

    bus_scheduler #(.SLOT_LEN(8)) dut_b (
        .clk16_i(clk16), .reset_i(reset),
        .spi_valid_i(1'b0), .spi_ready_o(b_spi_ready), .spi_en_o(b_spi_en),
        .vid_req_i(1'b0), .vid_ack_o(b_vid_ack), .vid_en_o(b_vid_en),
        .cpu_en_o(b_cpu_en), .cpu_be_o(b_cpu_be), .cpu_clk_o(b_cpu_clk),
        .strobe_o(b_strobe), .slot_o(b_slot)
    );

    // {vid_en, vid_ack, spi_en, spi_ready, cpu_en, cpu_be, cpu_clk, strobe, slot}
    logic [9:0] obs_a, obs_b;
    assign obs_a = {a_vid_en, a_vid_ack, a_spi_en, a_spi_ready, a_cpu_en, a_cpu_be,
                    a_cpu_clk, a_strobe, a_slot};
    assign obs_b = {b_vid_en, b_vid_ack, b_spi_en, b_spi_ready, b_cpu_en, b_cpu_be,
                    b_cpu_clk, b_strobe, b_slot};

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    task automatic step();
        @(posedge clk16);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [9:0] obs,
                         input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    // Expected outputs at cycle c of a frame, given which grants that frame should carry.
    function automatic logic [9:0] exp_vec(input int c, input int sl, input bit vg,
                                           input bit sg, input bit stg);
        int  slot;
        int  ph;
        bit  v, s, cpu, last, sh;
        slot = c / sl;
        ph   = c % sl;
        v    = (slot == 0) && vg;
        s    = ((slot == 1) && sg) || ((slot == 0) && stg);
        cpu  = (slot == 3);
        last = (ph == sl - 1);
        sh   = (ph >= sl / 2);
        return {v, v && last, s, s && last, cpu, slot >= 2, cpu, sh && (v || s || cpu),
                2'(slot)};
    endfunction

    task automatic check_frame(input string tag, input int sl, input bit vg, input bit sg,
                               input bit stg, input int set_at, input bit set_vid,
                               input bit set_spi, input bit drop_spi);
        for (int c = 0; c < 4 * sl; c++) begin
            check(tag, c, (sl == 4) ? obs_a : obs_b, exp_vec(c, sl, vg, sg, stg));
            if (drop_spi && a_spi_ready) spi_valid = 1'b0;
            if (c == set_at) begin
                vid_req   = set_vid;
                spi_valid = set_spi;
            end
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        vid_req   = 1'b0;
        spi_valid = 1'b0;
        repeat (3) step();
        check("rst_a", 0, obs_a, 10'b0);
        check("rst_b", 0, obs_b, 10'b0);

        // Requests present during reset: reset wins.
        vid_req   = 1'b1;
        spi_valid = 1'b1;
        step();
        check("rst_req_a", 0, obs_a, 10'b0);
        vid_req   = 1'b0;
        spi_valid = 1'b0;
        reset     = 1'b0;
        step();

        // SLOT_LEN=8 idle frame; the SLOT_LEN=4 instance runs two idle frames meanwhile.
        check_frame("len8_idle", 8, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        check_frame("spi_single", 4, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1);
        check_frame("spi_no_regrant", 4, 1'b0, 1'b0, 1'b0, 15, 1'b1, 1'b1, 1'b0);
        check_frame("both_f1", 4, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0);
        check_frame("both_f2", 4, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0);

        // Reset during the SPI grant drops it with no ready pulse.
        for (int c = 0; c < 6; c++) begin
            check("rst_mid_pre", c, obs_a, exp_vec(c, 4, 1'b1, 1'b1, 1'b0));
            if (c == 5) reset = 1'b1;
            step();
        end
        check("rst_mid", 6, obs_a, 10'b0);
        reset = 1'b0;
        step();

        check_frame("after_rst", 4, 1'b1, 1'b1, 1'b0, 15, 1'b0, 1'b1, 1'b0);
`ifdef BUS_SCHED_SPI_STEAL_EN
        check_frame("steal", 4, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b1);
`else
        check_frame("no_steal", 4, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1);
`endif
        check_frame("idle_end", 4, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
